// File: rtl/vend_if.sv
// Selection/coin/hopper handshake bundle for vend_dispense.
// master = selection front-end side, slave = dispense controller.
interface vend_if #(
  parameter int unsigned CREDIT_W = 5
);
  logic                coin1;
  logic                coin5;
  logic                get2;
  logic                get6;
  logic                backAll;
  logic                ret_rdy;
  logic [CREDIT_W-1:0] credit;
  logic                item2;
  logic                item6;
  logic                deny;
  logic                coin_rej;
  logic                ret5;
  logic                ret1;
  logic                busy;

  modport master (
    output coin1, coin5, get2, get6, backAll, ret_rdy,
    input  credit, item2, item6, deny, coin_rej, ret5, ret1, busy
  );

  modport slave (
    input  coin1, coin5, get2, get6, backAll, ret_rdy,
    output credit, item2, item6, deny, coin_rej, ret5, ret1, busy
  );
endinterface

// File: rtl/vend_dispense.sv
// Vending dispense controller: credit keeping, purchase/refund commands, coin-by-coin payout.
// Optional feature: define VEND_AUTO_CHANGE_EN to pay change automatically after every sale.
module vend_dispense #(
  parameter int unsigned PRICE_A    = 2,
  parameter int unsigned PRICE_B    = 6,
  parameter int unsigned CREDIT_W   = 5,
  parameter int unsigned CREDIT_MAX = 31
) (
  input  logic   clk,
  input  logic   rst_n,
  vend_if.slave  bus
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  localparam logic [CREDIT_W-1:0] PA_W   = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PB_W   = CREDIT_W'(PRICE_B);
  localparam logic [CREDIT_W-1:0] FIVE_W = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] ONE_W  = CREDIT_W'(1);
  localparam logic [SUM_W-1:0]    MAX_W  = SUM_W'(CREDIT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    CHANGE
  } state_t;

  state_t              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic                item2_q, item6_q, deny_q, coin_rej_q, ret5_q, ret1_q, busy_q;

  logic                any_coin_c;
  logic                any_cmd_c;
  logic [SUM_W-1:0]    amount_c;
  logic [SUM_W-1:0]    sum_c;
  logic                pay5_c;
  logic [CREDIT_W-1:0] paid_c;

  // Coin-add check is one bit wider than credit so it cannot wrap; payout picks the largest coin.
  always_comb begin
    any_coin_c = bus.coin1 | bus.coin5;
    any_cmd_c  = bus.backAll | bus.get6 | bus.get2;
    amount_c   = (bus.coin1 ? SUM_W'(1) : '0) + (bus.coin5 ? SUM_W'(5) : '0);
    sum_c      = {1'b0, credit_q} + amount_c;
    pay5_c     = (credit_q >= FIVE_W);
    paid_c     = credit_q - (pay5_c ? FIVE_W : ONE_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      item2_q    <= 1'b0;
      item6_q    <= 1'b0;
      deny_q     <= 1'b0;
      coin_rej_q <= 1'b0;
      ret5_q     <= 1'b0;
      ret1_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      item2_q    <= 1'b0;
      item6_q    <= 1'b0;
      deny_q     <= 1'b0;
      coin_rej_q <= 1'b0;
      ret5_q     <= 1'b0;
      ret1_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_cmd_c) begin
            coin_rej_q <= any_coin_c;
            if (bus.backAll) begin
              if (credit_q != '0) begin
                state_q <= CHANGE;
                busy_q  <= 1'b1;
              end
            end else if (bus.get6) begin
              if (credit_q >= PB_W) begin
                credit_q <= credit_q - PB_W;
                item6_q  <= 1'b1;
                state_q  <= DISPENSE;
                busy_q   <= 1'b1;
              end else begin
                deny_q <= 1'b1;
              end
            end else begin
              if (credit_q >= PA_W) begin
                credit_q <= credit_q - PA_W;
                item2_q  <= 1'b1;
                state_q  <= DISPENSE;
                busy_q   <= 1'b1;
              end else begin
                deny_q <= 1'b1;
              end
            end
          end else if (any_coin_c) begin
            if (sum_c <= MAX_W) begin
              credit_q <= sum_c[CREDIT_W-1:0];
            end else begin
              coin_rej_q <= 1'b1;
            end
          end
        end

        DISPENSE: begin
          coin_rej_q <= any_coin_c;
`ifdef VEND_AUTO_CHANGE_EN
          // First change coin can go out on the edge that leaves DISPENSE.
          if (credit_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (bus.ret_rdy) begin
            ret5_q   <= pay5_c;
            ret1_q   <= ~pay5_c;
            credit_q <= paid_c;
            if (paid_c == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= CHANGE;
            end
          end else begin
            state_q <= CHANGE;
          end
`else
          state_q <= IDLE;
          busy_q  <= 1'b0;
`endif
        end

        CHANGE: begin
          coin_rej_q <= any_coin_c;
          if (bus.ret_rdy) begin
            ret5_q   <= pay5_c;
            ret1_q   <= ~pay5_c;
            credit_q <= paid_c;
            if (paid_c == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.credit   = credit_q;
  assign bus.item2    = item2_q;
  assign bus.item6    = item6_q;
  assign bus.deny     = deny_q;
  assign bus.coin_rej = coin_rej_q;
  assign bus.ret5     = ret5_q;
  assign bus.ret1     = ret1_q;
  assign bus.busy     = busy_q;

endmodule
